ped_crossing_ctrl: RTL and testbench

Pedestrian-side controller for the one-lane vehicle signal. It debounces the physical crossing button and drives a level `ped_request` into the vehicle controller's pedestrian input. It observes the vehicle red/yellow/green lamps and drives walk, don't-walk and wait lamps, granting walk only inside a vehicle red phase it has seen begin. It also flags any illegal vehicle lamp combination.

---
 rtl/ped_pkg.sv | 28 ++
 rtl/ped_button_debounce.sv | 54 +++++
 rtl/ped_crossing_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ped_pkg.sv
// Shared types and constants for the pedestrian crossing controller.
// Vehicle lamps are packed as {red, yellow, green}.
package ped_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RED,
    ST_WALK,
    ST_FLASH,
    ST_CLEAR,
    ST_FAULT
  } ped_state_e;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam int TICK_DIV_DEF   = 50;
  localparam int DEBOUNCE_DEF   = 4;
  localparam int WALK_SECS_DEF  = 6;
  localparam int FLASH_SECS_DEF = 3;

  function automatic logic lamps_legal(input logic [2:0] lamps);
    return (lamps == LAMP_RED) || (lamps == LAMP_YELLOW) || (lamps == LAMP_GREEN);
  endfunction

endpackage

// File: rtl/ped_button_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stability counter and
// a single-cycle pulse on the rising edge of the debounced level.
module ped_button_debounce
  import ped_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    // Counter saturates at DEBOUNCE so a held button yields one edge only.
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(DEBOUNCE)) begin
      cnt_d = cnt_q + CW'(1);
    end
    level_d = (cnt_d == CW'(DEBOUNCE));
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-side crossing controller: requests a vehicle red, grants walk
// only inside a red phase it saw begin, and latches illegal lamp states.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no request, don't-walk solid
// REQ      | ped_request asserted, waiting for vehicle yellow
// WAIT_RED | request accepted, waiting for the red phase to start
// WALK     | walk lamp solid for WALK_SECS ticks
// FLASH    | don't-walk blinking for FLASH_SECS ticks
// CLEAR    | don't-walk solid until vehicle red ends
// FAULT    | illegal vehicle lamps seen, held until reset
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DEBOUNCE   = DEBOUNCE_DEF,
  parameter int WALK_SECS  = WALK_SECS_DEF,
  parameter int FLASH_SECS = FLASH_SECS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic veh_red,
  input  logic veh_yellow,
  input  logic veh_green,
  output logic ped_request,
  output logic walk,
  output logic dont_walk,
  output logic wait_lamp,
  output logic fault
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMR_W = $clog2(WALK_SECS + FLASH_SECS + 1);

  ped_state_e   state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic         queued_q, queued_d;
  logic         ped_request_q, ped_request_d;
  logic         walk_q, walk_d;
  logic         dont_walk_q, dont_walk_d;
  logic         wait_lamp_q, wait_lamp_d;
  logic         fault_q, fault_d;

  logic         press;
  logic         tick;
  logic         walk_done;
  logic         flash_done;
  logic         lamp_fault;
  logic [2:0]   lamps;

  ped_button_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .press   (press)
  );

  assign tick  = (div_q == DIV_W'(TICK_DIV - 1));
  assign lamps = {veh_red, veh_yellow, veh_green};

  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    queued_d   = queued_q;
    walk_done  = tick && (timer_q == TMR_W'(WALK_SECS - 1));
    flash_done = tick && (timer_q == TMR_W'(FLASH_SECS - 1));
    lamp_fault = !lamps_legal(lamps) ||
                 (veh_green && (state_q == ST_WALK || state_q == ST_FLASH));

    if (press && (state_q inside {ST_WAIT_RED, ST_WALK, ST_FLASH, ST_CLEAR})) begin
      queued_d = 1'b1;
    end

    if (lamp_fault) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE:     if (press) state_d = ST_REQ;
        ST_REQ:      if (veh_yellow) state_d = ST_WAIT_RED;
        ST_WAIT_RED: if (veh_red) state_d = ST_WALK;
        // Early red drop takes precedence over phase expiry.
        ST_WALK: begin
          if (!veh_red)       state_d = ST_CLEAR;
          else if (walk_done) state_d = ST_FLASH;
        end
        ST_FLASH: begin
          if (!veh_red)        state_d = ST_CLEAR;
          else if (flash_done) state_d = ST_CLEAR;
        end
        ST_CLEAR: begin
          if (!veh_red) begin
            if (queued_d) begin
              state_d  = ST_REQ;
              queued_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_FAULT;
      endcase
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick) begin
      timer_d = timer_q + TMR_W'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // Lamp outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_comb begin
    ped_request_d = (state_d == ST_REQ);
    wait_lamp_d   = (state_d == ST_REQ) || (state_d == ST_WAIT_RED);
    walk_d        = (state_d == ST_WALK);
    fault_d       = (state_d == ST_FAULT);
    case (state_d)
      ST_WALK:  dont_walk_d = 1'b0;
      ST_FLASH: begin
        if (state_q != ST_FLASH) dont_walk_d = 1'b0;
        else if (tick)           dont_walk_d = ~dont_walk_q;
        else                     dont_walk_d = dont_walk_q;
      end
      default:  dont_walk_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      div_q         <= '0;
      timer_q       <= '0;
      queued_q      <= 1'b0;
      ped_request_q <= 1'b0;
      walk_q        <= 1'b0;
      dont_walk_q   <= 1'b1;
      wait_lamp_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      timer_q       <= timer_d;
      queued_q      <= queued_d;
      ped_request_q <= ped_request_d;
      walk_q        <= walk_d;
      dont_walk_q   <= dont_walk_d;
      wait_lamp_q   <= wait_lamp_d;
      fault_q       <= fault_d;
    end
  end

  assign ped_request = ped_request_q;
  assign walk        = walk_q;
  assign dont_walk   = dont_walk_q;
  assign wait_lamp   = wait_lamp_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: directed scenarios plus random button and
// vehicle sequences, every cycle compared against a behavioural model.
module tb_ped_crossing_ctrl;

  localparam int TD  = 8;
  localparam int DEB = 4;
  localparam int WS  = 6;
  localparam int FS  = 3;

  localparam int M_IDLE = 0, M_REQ = 1, M_WAITR = 2, M_WALK = 3,
                 M_FLASH = 4, M_CLEAR = 5, M_FAULT = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic veh_red = 1'b0, veh_yellow = 1'b0, veh_green = 1'b1;
  logic ped_request, walk, dont_walk, wait_lamp, fault;

  int total = 0;
  int bad   = 0;

  // model state
  int  m_st, m_e, m_tc, m_start;
  bit  m_q;
  int  hist[$];
  logic exp_req, exp_walk, exp_dw, exp_wait, exp_fault;

  bit  rand_btn = 1'b0;
  int  btn_left = 0;

  ped_crossing_ctrl #(
    .TICK_DIV   (TD),
    .DEBOUNCE   (DEB),
    .WALK_SECS  (WS),
    .FLASH_SECS (FS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .veh_red     (veh_red),
    .veh_yellow  (veh_yellow),
    .veh_green   (veh_green),
    .ped_request (ped_request),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .wait_lamp   (wait_lamp),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_st = M_IDLE; m_q = 1'b0; m_e = 0; m_tc = 0; m_start = 0;
    hist = {0, 0, 0, 0};
    exp_req = 0; exp_walk = 0; exp_dw = 1; exp_wait = 0; exp_fault = 0;
  endtask

  // Press reaches the controller 3 edges after the raw run of ones hits DEB.
  task automatic model_edge(input logic b, input logic r, input logic y, input logic g);
    int rl, nst;
    bit tk, pr, legal, qe;
    m_e++;
    tk = ((m_e % TD) == 0);
    rl = b ? hist[0] + 1 : 0;
    hist.push_front(rl);
    if (hist.size() > 8) void'(hist.pop_back());
    pr = (hist[3] == DEB);
    legal = ((int'(r) + int'(y) + int'(g)) == 1);
    qe = m_q || (pr && (m_st == M_WAITR || m_st == M_WALK || m_st == M_FLASH || m_st == M_CLEAR));
    if (tk) m_tc++;
    nst = m_st;
    if (!legal || (g && (m_st == M_WALK || m_st == M_FLASH))) begin
      nst = M_FAULT;
    end else begin
      case (m_st)
        M_IDLE:  if (pr) nst = M_REQ;
        M_REQ:   if (y) nst = M_WAITR;
        M_WAITR: if (r) nst = M_WALK;
        M_WALK:  if (!r) nst = M_CLEAR; else if (tk && (m_tc - m_start) == WS) nst = M_FLASH;
        M_FLASH: if (!r) nst = M_CLEAR; else if (tk && (m_tc - m_start) == FS) nst = M_CLEAR;
        M_CLEAR: if (!r) nst = qe ? M_REQ : M_IDLE;
        default: nst = M_FAULT;
      endcase
    end
    m_q = (m_st == M_CLEAR && nst == M_REQ) ? 1'b0 : qe;
    if (nst != m_st) m_start = m_tc;
    m_st = nst;
    exp_req   = (m_st == M_REQ);
    exp_wait  = (m_st == M_REQ) || (m_st == M_WAITR);
    exp_walk  = (m_st == M_WALK);
    exp_fault = (m_st == M_FAULT);
    if (m_st == M_WALK)       exp_dw = 1'b0;
    else if (m_st == M_FLASH) exp_dw = ((m_tc - m_start) % 2) == 1;
    else                      exp_dw = 1'b1;
  endtask

  task automatic check_outputs();
    total++;
    assert (ped_request === exp_req) else begin
      bad++; $error("FAIL ped_request obs=%0b exp=%0b t=%0t", ped_request, exp_req, $time);
    end
    total++;
    assert (walk === exp_walk) else begin
      bad++; $error("FAIL walk obs=%0b exp=%0b t=%0t", walk, exp_walk, $time);
    end
    total++;
    assert (dont_walk === exp_dw) else begin
      bad++; $error("FAIL dont_walk obs=%0b exp=%0b t=%0t", dont_walk, exp_dw, $time);
    end
    total++;
    assert (wait_lamp === exp_wait) else begin
      bad++; $error("FAIL wait_lamp obs=%0b exp=%0b t=%0t", wait_lamp, exp_wait, $time);
    end
    total++;
    assert (fault === exp_fault) else begin
      bad++; $error("FAIL fault obs=%0b exp=%0b t=%0t", fault, exp_fault, $time);
    end
  endtask

  task automatic step(input logic rs, input logic b, input logic r, input logic y, input logic g);
    logic bb;
    bb = b;
    if (rand_btn) begin
      if (btn_left > 0) begin
        btn_left--; bb = 1'b1;
      end else if ($urandom_range(0, 24) == 0) begin
        btn_left = int'($urandom_range(1, 12));
      end
    end
    rst = rs; btn_raw = bb; veh_red = r; veh_yellow = y; veh_green = g;
    if (rs) model_reset();
    else    model_edge(bb, r, y, g);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n, input logic b, input logic r, input logic y, input logic g);
    for (int i = 0; i < n; i++) step(1'b0, b, r, y, g);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++; $error("FAIL %s obs=%0b exp=%0b", tag, obs, expv);
    end
  endtask

  initial begin
    int first_req, walk_cyc;
    bit saw_req, walk_seen;
    int gl, yl, rl2;

    // reset with random inputs
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    // short press is filtered
    saw_req = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step(1'b0, (i < 3), 1'b0, 1'b0, 1'b1);
      if (ped_request) saw_req = 1'b1;
    end
    check_bit("short_press_no_req", saw_req, 1'b0);

    // held press during green: request on the seventh edge, once
    first_req = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      if (ped_request && first_req == 0) first_req = k;
    end
    total++;
    assert (first_req === 2 + DEB + 1) else begin
      bad++; $error("FAIL req_latency obs=%0d exp=%0d", first_req, 2 + DEB + 1);
    end
    run(20, 1'b0, 1'b0, 1'b0, 1'b1);
    check_bit("req_held_in_green", ped_request, 1'b1);

    // full cycle
    run(8, 1'b0, 1'b0, 1'b1, 1'b0);
    check_bit("req_dropped_after_yellow", ped_request, 1'b0);
    walk_cyc = 0;
    for (int i = 0; i < 10 * TD; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 0) check_bit("walk_after_red_edge", walk, 1'b1);
      if (walk) walk_cyc++;
    end
    total++;
    assert (walk_cyc > 5 * TD && walk_cyc <= 6 * TD) else begin
      bad++; $error("FAIL walk_duration obs=%0d exp=%0d..%0d", walk_cyc, 5 * TD + 1, 6 * TD);
    end
    run(10, 1'b0, 1'b0, 1'b0, 1'b1);
    check_bit("idle_after_red", wait_lamp, 1'b0);

    // press while red in IDLE: that red is not served
    walk_seen = 1'b0;
    for (int i = 0; i < 10 * TD; i++) begin
      step(1'b0, (i < 6), 1'b1, 1'b0, 1'b0);
      if (walk) walk_seen = 1'b1;
    end
    check_bit("no_walk_in_seen_red", walk_seen, 1'b0);
    check_bit("req_pending_in_red", ped_request, 1'b1);
    run(10, 1'b0, 1'b0, 1'b0, 1'b1);
    run(8, 1'b0, 1'b0, 1'b1, 1'b0);
    // next red is served; press during walk is queued
    walk_seen = 1'b0;
    for (int i = 0; i < 10 * TD; i++) begin
      step(1'b0, (i >= 2 * TD && i < 2 * TD + 6), 1'b1, 1'b0, 1'b0);
      if (walk) walk_seen = 1'b1;
    end
    check_bit("walk_in_next_red", walk_seen, 1'b1);
    run(5, 1'b0, 1'b0, 1'b0, 1'b1);
    check_bit("queued_req", ped_request, 1'b1);
    check_bit("queued_wait", wait_lamp, 1'b1);

    // early red drop two ticks into walk
    run(8, 1'b0, 1'b0, 1'b1, 1'b0);
    run(2 * TD, 1'b0, 1'b1, 1'b0, 1'b0);
    check_bit("walk_before_drop", walk, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_bit("early_drop_walk", walk, 1'b0);
    check_bit("early_drop_dw", dont_walk, 1'b1);
    run(4, 1'b0, 1'b0, 1'b1, 1'b0);

    // random button and vehicle sequences
    rand_btn = 1'b1;
    for (int c = 0; c < 30; c++) begin
      gl = int'($urandom_range(10, 40));
      yl = int'($urandom_range(4, 10));
      rl2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 9)) * TD : 10 * TD;
      run(gl, 1'b0, 1'b0, 1'b0, 1'b1);
      run(yl, 1'b0, 1'b0, 1'b1, 1'b0);
      run(rl2, 1'b0, 1'b1, 1'b0, 1'b0);
      if (rl2 < 10 * TD) run(3, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    rand_btn = 1'b0;
    btn_left = 0;

    // illegal lamps latch fault
    run(10, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_bit("fault_set", fault, 1'b1);
    check_bit("fault_walk_off", walk, 1'b0);
    run(10, 1'b1, 1'b0, 1'b0, 1'b1);
    run(8, 1'b0, 1'b0, 1'b1, 1'b0);
    run(20, 1'b0, 1'b1, 1'b0, 1'b0);
    check_bit("fault_sticky", fault, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_bit("fault_cleared_by_rst", fault, 1'b0);
    run(5, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
